// File: rtl/mysystem_binaryscale_ctrl_if.sv
// Avalon-MM slave bus bundle for the binary-scale switch controller.
// The bundle carries register access signals plus the level interrupt.
interface mysystem_binaryscale_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/mysystem_binaryscale_ctrl.sv
// Binary-scale switch controller: synchroniser, optional debounce (BINARYSCALE_DEBOUNCE_EN),
// per-bit change capture with W1C clear, maskable level irq, Avalon-MM registers.
module mysystem_binaryscale_ctrl #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   mysystem_binaryscale_ctrl_if.slave bus,
   input  logic [WIDTH-1:0]        in_port
);

   logic [WIDTH-1:0] meta_q, sync_q;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] clr_s;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      stat_s;
   logic             wr_s;
   logic [31:0]      unused_wdata_s;

   assign wr_s           = bus.chipselect & ~bus.write_n;
   assign unused_wdata_s = bus.writedata;

`ifdef BINARYSCALE_DEBOUNCE_EN
   typedef enum logic {ST_STABLE = 1'b0, ST_SETTLE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sync_prev_q;

   // Debounce FSM: any synced change restarts the hold window; a return to
   // the accepted value abandons the settle without touching deb.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      case (state_q)
         ST_STABLE: begin
            if (sync_q != deb_q) begin
               state_d = ST_SETTLE;
               cnt_d   = RELOAD;
            end else begin
               state_d = ST_STABLE;
            end
         end
         ST_SETTLE: begin
            if (sync_q != sync_prev_q) begin
               cnt_d = RELOAD;
            end else if (sync_q == deb_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == {CNT_W{1'b0}}) begin
               deb_d   = sync_q;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_STABLE;
         end
      endcase
   end

   // Status word: settling flag and live counter.
   always_comb begin
      stat_s              = 32'd0;
      stat_s[0]           = (state_q == ST_SETTLE);
      stat_s[16 +: CNT_W] = cnt_q;
   end

   // Debounce state, counter and previous-cycle sync sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_STABLE;
         cnt_q       <= {CNT_W{1'b0}};
         sync_prev_q <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync_prev_q <= sync_q;
      end
   end
`else
   logic [CNT_W-1:0] unused_cfg_s;

   assign unused_cfg_s = CNT_W'(DEBOUNCE_CYCLES);

   // Without debounce the synced value is accepted every cycle.
   always_comb begin
      deb_d  = sync_q;
      stat_s = 32'd0;
   end
`endif

   // Mask/edge updates, irq source and read mux. Edge set has priority over W1C.
   always_comb begin
      if (wr_s && (bus.address == 2'd1)) begin
         mask_d = bus.writedata[WIDTH-1:0];
      end else begin
         mask_d = mask_q;
      end
      if (wr_s && (bus.address == 2'd2)) begin
         clr_s = bus.writedata[WIDTH-1:0];
      end else begin
         clr_s = {WIDTH{1'b0}};
      end
      edge_d = (edge_q & ~clr_s) | (deb_d ^ deb_q);
      irq_d  = |(edge_q & mask_q);
      case (bus.address)
         2'd0:    rdata_d = 32'(deb_q);
         2'd1:    rdata_d = 32'(mask_q);
         2'd2:    rdata_d = 32'(edge_q);
         2'd3:    rdata_d = stat_s;
         default: rdata_d = 32'd0;
      endcase
   end

   // Synchroniser chain and all register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q  <= {WIDTH{1'b0}};
         sync_q  <= {WIDTH{1'b0}};
         deb_q   <= {WIDTH{1'b0}};
         mask_q  <= {WIDTH{1'b0}};
         edge_q  <= {WIDTH{1'b0}};
         irq_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         meta_q  <= in_port;
         sync_q  <= meta_q;
         deb_q   <= deb_d;
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign bus.irq      = irq_q;

endmodule
